// File: rtl/fma_issue_ctrl.sv
// ============================================================================
// Module   : fma_issue_ctrl
// Purpose  : Issues one FMA request at a time to a multi-cycle FMA unit,
//            applies the op-dependent sign flips, waits for the result strobe
//            (with timeout) and presents a valid/ready response.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fma_issue_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_rs3,
    input  logic [4:0]  req_rd,
    output logic [31:0] fma_a,
    output logic [31:0] fma_b,
    output logic [31:0] fma_c,
    output logic        fma_rst,
    input  logic [31:0] fma_z,
    input  logic        fma_z_stb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_timeout
);

    localparam logic [31:0] C_QNAN      = 32'h7FC0_0000;
    localparam logic [7:0]  C_LAST_WAIT = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      state_q;
    logic [7:0]  wait_cnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] c_q;
    logic [4:0]  rd_q;
    logic        req_ready_q;
    logic        fma_rst_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic [4:0]  rsp_rd_q;
    logic        rsp_timeout_q;

    logic [31:0] a_d;
    logic [31:0] c_d;

    // op[1] negates the product (flip a), op[0] negates the addend (flip c)
    always_comb begin
        a_d = {req_rs1[31] ^ req_op[1], req_rs1[30:0]};
        c_d = {req_rs3[31] ^ req_op[0], req_rs3[30:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= 8'd0;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            c_q           <= 32'd0;
            rd_q          <= 5'd0;
            req_ready_q   <= 1'b1;
            fma_rst_q     <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 32'd0;
            rsp_rd_q      <= 5'd0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        a_q         <= a_d;
                        b_q         <= req_rs2;
                        c_q         <= c_d;
                        rd_q        <= req_rd;
                        req_ready_q <= 1'b0;
                        fma_rst_q   <= 1'b0;
                        state_q     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wait_cnt_q <= 8'd0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    // A strobe on the last wait cycle still wins over the timeout
                    if (fma_z_stb) begin
                        rsp_data_q    <= fma_z;
                        rsp_timeout_q <= 1'b0;
                        rsp_rd_q      <= rd_q;
                        rsp_valid_q   <= 1'b1;
                        fma_rst_q     <= 1'b1;
                        state_q       <= S_RESP;
                    end else if (wait_cnt_q == C_LAST_WAIT) begin
                        rsp_data_q    <= C_QNAN;
                        rsp_timeout_q <= 1'b1;
                        rsp_rd_q      <= rd_q;
                        rsp_valid_q   <= 1'b1;
                        fma_rst_q     <= 1'b1;
                        state_q       <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    fma_rst_q   <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign fma_a       = a_q;
    assign fma_b       = b_q;
    assign fma_c       = c_q;
    assign fma_rst     = fma_rst_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_rd      = rsp_rd_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_fma_issue_ctrl.sv
// ============================================================================
// Module   : tb_fma_issue_ctrl
// Purpose  : Randomized and directed bench for fma_issue_ctrl against a
//            transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fma_issue_ctrl;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1, req_rs2, req_rs3;
    logic [4:0]  req_rd;
    logic [31:0] fma_a, fma_b, fma_c;
    logic        fma_rst;
    logic [31:0] fma_z;
    logic        fma_z_stb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_timeout;

    int total = 0;
    int bad   = 0;

    fma_issue_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .req_rd(req_rd),
        .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_rst(fma_rst),
        .fma_z(fma_z), .fma_z_stb(fma_z_stb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s wait bound expired t=%0t", name, $time);
    endtask

    // Reference model: a request in flight is tracked by its age in cycles
    // since acceptance (1 = launch cycle, 2 + w = w-th wait cycle).
    function automatic logic [31:0] neg_if(input logic [31:0] v, input bit n);
        return n ? (v ^ 32'h8000_0000) : v;
    endfunction

    bit          m_busy, m_resp, m_to;
    int          m_age;
    logic [31:0] m_a, m_b, m_c, m_data;
    logic [4:0]  m_rd_pend, m_rd;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 0; m_resp <= 0; m_age <= 0; m_to <= 0;
            m_a <= '0; m_b <= '0; m_c <= '0; m_data <= '0;
            m_rd_pend <= '0; m_rd <= '0;
        end else if (m_resp) begin
            if (rsp_ready) m_resp <= 0;
        end else if (m_busy) begin
            if (m_age >= 2 && fma_z_stb) begin
                m_busy <= 0; m_resp <= 1; m_data <= fma_z; m_to <= 0; m_rd <= m_rd_pend;
            end else if (m_age - 2 == TO - 1) begin
                m_busy <= 0; m_resp <= 1; m_data <= 32'h7FC0_0000; m_to <= 1; m_rd <= m_rd_pend;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (req_valid) begin
            m_busy <= 1; m_age <= 1; m_rd_pend <= req_rd; m_b <= req_rs2;
            case (req_op)
                2'd0: begin m_a <= req_rs1;            m_c <= req_rs3;            end
                2'd1: begin m_a <= req_rs1;            m_c <= neg_if(req_rs3, 1); end
                2'd2: begin m_a <= neg_if(req_rs1, 1); m_c <= req_rs3;            end
                default: begin m_a <= neg_if(req_rs1, 1); m_c <= neg_if(req_rs3, 1); end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("req_ready",   {31'd0, req_ready},   {31'd0, !m_busy && !m_resp});
        chk("fma_rst",     {31'd0, fma_rst},     {31'd0, !m_busy});
        chk("rsp_valid",   {31'd0, rsp_valid},   {31'd0, m_resp});
        chk("rsp_data",    rsp_data,             m_data);
        chk("rsp_rd",      {27'd0, rsp_rd},      {27'd0, m_rd});
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, m_to});
        chk("fma_a",       fma_a,                m_a);
        chk("fma_b",       fma_b,                m_b);
        chk("fma_c",       fma_c,                m_c);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full request/response; sdelay<0 means the FMA never strobes.
    task automatic do_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [4:0] rd, input logic [31:0] z,
                          input int sdelay, input int rdelay, input bit noise,
                          output logic [31:0] oa, output logic [31:0] ob, output logic [31:0] oc,
                          output logic [31:0] odata, output logic [4:0] ord, output logic oto,
                          output logic ofrst, output int lat);
        int g = 0;
        while (!req_ready && g < 200) begin tick(); g++; end
        if (g >= 200) bound_fail("req_ready_wait");
        req_valid = 1; req_op = op; req_rs1 = a; req_rs2 = b; req_rs3 = c; req_rd = rd;
        tick();
        req_valid = 0;
        req_op = 2'($urandom); req_rs1 = $urandom; req_rs2 = $urandom; req_rs3 = $urandom;
        req_rd = 5'($urandom);
        oa = fma_a; ob = fma_b; oc = fma_c;
        if (noise) begin fma_z_stb = 1; fma_z = $urandom; end
        tick();
        fma_z_stb = 0;
        lat = 0;
        if (sdelay >= 0) begin
            repeat (sdelay) begin tick(); lat++; end
            fma_z_stb = 1; fma_z = z;
            tick(); lat++;
            fma_z_stb = 0; fma_z = $urandom;
        end
        while (!rsp_valid && lat < 300) begin tick(); lat++; end
        if (!rsp_valid) bound_fail("rsp_valid_wait");
        odata = rsp_data; ord = rsp_rd; oto = rsp_timeout; ofrst = fma_rst;
        repeat (rdelay) tick();
        rsp_ready = 1;
        req_valid = noise;
        tick();
        rsp_ready = 0;
        req_valid = 0;
    endtask

    logic [31:0] oa, ob, oc, odata;
    logic [4:0]  ord;
    logic        oto, ofrst;
    int          lat;

    initial begin
        rst = 0; req_valid = 0; req_op = 0; req_rs1 = 0; req_rs2 = 0; req_rs3 = 0;
        req_rd = 0; fma_z = 0; fma_z_stb = 0; rsp_ready = 0;
        repeat (3) tick();
        chk("reset_fma_rst",   {31'd0, fma_rst},   32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_data",  rsp_data,           32'd0);
        chk("reset_fma_a",     fma_a,              32'd0);
        rst = 1;
        tick();
        chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

        do_txn(2'd0, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd5, 32'h40E0_0000,
               12, 0, 0, oa, ob, oc, odata, ord, oto, ofrst, lat);
        chk("fmadd_data", odata, 32'h40E0_0000);
        chk("fmadd_rd",   {27'd0, ord}, 32'd5);
        chk("fmadd_to",   {31'd0, oto}, 32'd0);
        chk("fmadd_lat",  lat, 32'd13);
        chk("fmadd_a",    oa, 32'h4000_0000);
        chk("fmadd_c",    oc, 32'h3F80_0000);

        do_txn(2'd3, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd9, 32'h1111_2222,
               3, 1, 0, oa, ob, oc, odata, ord, oto, ofrst, lat);
        chk("fnmadd_a", oa, 32'hC000_0000);
        chk("fnmadd_b", ob, 32'h4040_0000);
        chk("fnmadd_c", oc, 32'hBF80_0000);

        do_txn(2'd1, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd2, 32'h2222_3333,
               0, 0, 1, oa, ob, oc, odata, ord, oto, ofrst, lat);
        chk("fmsub_a", oa, 32'h4000_0000);
        chk("fmsub_c", oc, 32'hBF80_0000);
        chk("fmsub_lat", lat, 32'd1);

        do_txn(2'd2, 32'hC120_0000, 32'h3F00_0000, 32'h0000_0001, 5'd17, 32'h0,
               -1, 5, 0, oa, ob, oc, odata, ord, oto, ofrst, lat);
        chk("fnmsub_a",     oa, 32'h4120_0000);
        chk("fnmsub_c",     oc, 32'h0000_0001);
        chk("timeout_data", odata, 32'h7FC0_0000);
        chk("timeout_flag", {31'd0, oto}, 32'd1);
        chk("timeout_lat",  lat, 32'd64);
        chk("timeout_frst", {31'd0, ofrst}, 32'd1);

        do_txn(2'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 5'd31, 32'h1234_5678,
               TO - 1, 2, 0, oa, ob, oc, odata, ord, oto, ofrst, lat);
        chk("lastcyc_data", odata, 32'h1234_5678);
        chk("lastcyc_to",   {31'd0, oto}, 32'd0);
        chk("lastcyc_lat",  lat, 32'd64);

        // Reset in the middle of a wait
        req_valid = 1; req_op = 2'd0; req_rs1 = 32'hAAAA_5555; req_rd = 5'd7;
        tick();
        req_valid = 0;
        repeat (10) tick();
        #2 rst = 0;
        #1;
        chk("midrst_fma_rst",   {31'd0, fma_rst},   32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        rst = 1;
        fma_z_stb = 1; fma_z = 32'hDEAD_BEEF;
        tick();
        fma_z_stb = 0;
        tick();
        chk("midrst_stb_ignored", {31'd0, rsp_valid}, 32'd0);
        do_txn(2'd1, 32'h4080_0000, 32'h4000_0000, 32'h4100_0000, 5'd3, 32'h4100_0000,
               4, 0, 0, oa, ob, oc, odata, ord, oto, ofrst, lat);
        chk("after_rst_data", odata, 32'h4100_0000);
        chk("after_rst_rd",   {27'd0, ord}, 32'd3);

        for (int i = 0; i < 25; i++) begin
            int sel, sd;
            int gap;
            gap = $urandom_range(0, 3);
            for (int k = 0; k < gap; k++) begin
                fma_z_stb = $urandom_range(0, 1) == 1;
                fma_z = $urandom;
                tick();
            end
            fma_z_stb = 0;
            sel = $urandom_range(0, 9);
            if (sel < 6)       sd = $urandom_range(0, 20);
            else if (sel == 6) sd = TO - 1;
            else if (sel == 7) sd = TO;
            else if (sel == 8) sd = -1;
            else               sd = TO - 2;
            do_txn(2'($urandom), $urandom, $urandom, $urandom, 5'($urandom), $urandom,
                   sd, $urandom_range(0, 4), $urandom_range(0, 1) == 1,
                   oa, ob, oc, odata, ord, oto, ofrst, lat);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
